// File: rtl/fetch_pc_gen_pkg.sv
// Shared IFU definitions: fetch FSM state encoding, reset PC default,
// instruction width, branch opcode and the hold-register layout.
package fetch_pc_gen_pkg;

    localparam int INS_W = 32;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    // Major opcode field ins[6:2] of conditional branches.
    localparam logic [4:0] BRANCH_OPCODE = 5'b11000;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        REQ   = ST_REQ,
        WAIT  = ST_WAIT,
        HOLD  = ST_HOLD,
        DRAIN = ST_DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [INS_W-1:0] ins;
        logic [31:0]      pc;
        logic             pred_taken;
    } hold_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator and instruction-memory sequencer.
// Holds the fetch PC, issues one memory request at a time, steers the next
// PC from the external predictor and presents each fetched instruction to
// decode over valid/ready. Execute redirects override everything.
//
// Ports:
//   clock_in, reset_in            clock, async active-high reset
//   imem_req_*                    request channel (valid/ready/addr)
//   imem_rsp_*                    in-order response (valid/data)
//   pred_ins_data_out/pc_addr_out instruction and PC offered to predictor
//   pred_taken_in/pred_pc_in      predictor decision and target
//   redirect_valid_in/pc_in       execute-stage redirect
//   dec_*                         instruction handoff to decode
//
// state | meaning
// IDLE  | just out of reset, no request yet
// REQ   | request for pc presented to memory
// WAIT  | request accepted, waiting for its response
// HOLD  | instruction captured, offered to decode
// DRAIN | waiting for a response made stale by a redirect, then discard
import fetch_pc_gen_pkg::*;

module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic             clock_in,
    input  logic             reset_in,
    output logic             imem_req_valid_out,
    input  logic             imem_req_ready_in,
    output logic [31:0]      imem_req_addr_out,
    input  logic             imem_rsp_valid_in,
    input  logic [INS_W-1:0] imem_rsp_data_in,
    output logic [INS_W-1:0] pred_ins_data_out,
    output logic [31:0]      pred_pc_addr_out,
    input  logic             pred_taken_in,
    input  logic [31:0]      pred_pc_in,
    input  logic             redirect_valid_in,
    input  logic [31:0]      redirect_pc_in,
    output logic             dec_valid_out,
    input  logic             dec_ready_in,
    output logic [INS_W-1:0] dec_ins_out,
    output logic [31:0]      dec_pc_out,
    output logic             dec_pred_taken_out
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         req_valid_q, req_valid_d;
    logic         dec_valid_q, dec_valid_d;
    hold_entry_t  hold_q, hold_d;

    logic         req_fire;
    logic [31:0]  next_pc;

    // req_valid_q is high exactly while in REQ.
    assign req_fire = req_valid_q & imem_req_ready_in;
    assign next_pc  = pred_taken_in ? align_word(pred_pc_in) : pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;

        if (redirect_valid_in) begin
            pc_d = align_word(redirect_pc_in);
        end

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                // An accepted request under a redirect still returns data
                // that must be thrown away.
                if (req_fire) begin
                    state_d = redirect_valid_in ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid_in) begin
                    state_d = imem_rsp_valid_in ? REQ : DRAIN;
                end else if (imem_rsp_valid_in) begin
                    hold_d.ins        = imem_rsp_data_in;
                    hold_d.pc         = pc_q;
                    hold_d.pred_taken = pred_taken_in;
                    pc_d              = next_pc;
                    state_d           = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid_in || dec_ready_in) begin
                    state_d = REQ;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid_in) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        req_valid_d = (state_d == REQ);
        dec_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            dec_valid_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_valid_q <= req_valid_d;
            dec_valid_q <= dec_valid_d;
            hold_q      <= hold_d;
        end
    end

    assign imem_req_valid_out = req_valid_q;
    assign imem_req_addr_out  = pc_q;
    assign pred_ins_data_out  = imem_rsp_data_in;
    assign pred_pc_addr_out   = pc_q;
    assign dec_valid_out      = dec_valid_q;
    assign dec_ins_out        = hold_q.ins;
    assign dec_pc_out         = hold_q.pc;
    assign dec_pred_taken_out = hold_q.pred_taken;

endmodule
